uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1250, giving clk cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port data_out  output  8  last correctly received byte.
REQ-006 SHALL have port data_valid  output  1  one-cycle pulse, data_out holds a new byte.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-008 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer preset to 1; all decisions use synchronized value rx_s.
REQ-010 SHALL implement frame format 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-012 IDLE -> START on rx_s == 0; bit counter cleared to 0.
REQ-013 START: after CLKS_PER_BIT/2 cycles (integer division) re-sample rx_s; 0 -> DATA with counter cleared; 1 -> IDLE, glitch rejected, no output.
REQ-014 DATA: sample rx_s every CLKS_PER_BIT cycles (bit centre); shift into bit index 0..7; after index 7 -> STOP.
REQ-015 STOP: after CLKS_PER_BIT cycles sample rx_s; 1 -> load data_out, pulse data_valid next cycle, -> IDLE; 0 -> pulse frame_err, data_out unchanged, -> WAIT_IDLE.
REQ-016 WAIT_IDLE -> IDLE only when rx_s == 1; continuous break (rx low) SHALL produce exactly one frame_err.
REQ-017 Cycle counter SHALL be 16 bits, reset to 0 on each state entry, and never wrap within a bit.
REQ-018 Back-to-back frames (start bit immediately after stop-bit centre) SHALL be received without loss.
REQ-019 data_valid and frame_err SHALL never be high in the same cycle.
REQ-020 data_out SHALL remain stable between data_valid pulses.
REQ-021 Latency: data_valid SHALL rise exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (+/-1) after the rx falling edge at the port.

Reset
REQ-022 On rst_n low, SHALL asynchronously force: state IDLE, counters 0, shift register 0x00, data_out 0x00, data_valid 0, frame_err 0, busy 0, synchronizer flops 1.
REQ-023 Reset asserted mid-frame SHALL discard the partial byte; after release, reception resumes from IDLE on the next falling edge.

Structure
REQ-024 State encoding constants and 8N1 frame constants (DATA_BITS=8) SHALL live in shared package uart_pkg, also used by the transmitter.
REQ-025 Synchronizer SHALL be sub-module sync_2ff (parameter RESET_VAL), reusable by other async inputs.
REQ-026 No other sub-modules; target 150-250 lines of RTL.

Verification (CLKS_PER_BIT=16)
REQ-027 Send 0xA5 framed correctly -> single data_valid pulse, data_out=0xA5, frame_err stays 0.
REQ-028 rx low for 4 cycles then high -> no data_valid, no frame_err, busy back to 0 within 10 cycles.
REQ-029 Send 0x3C with stop bit 0, then hold rx low 40 cycles -> exactly one frame_err pulse, data_out unchanged, busy high until rx returns to 1.
REQ-030 Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three data_valid pulses carrying 0x00, 0xFF, 0x55 in order.
REQ-031 Assert rst_n low during data bit 4 of 0x81, release, then send 0x7E -> all outputs at reset values during reset; next pulse carries 0x7E.
REQ-032 Transmitter clock off by +3% -> 0xC3 still received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: 8N1 frame constants and FSM state encoding shared by the UART receiver and transmitter.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned BIT_IDX_W  = $clog2(DATA_BITS);
    localparam int unsigned CNT_W      = 16;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;
    localparam logic        IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_e;

    // Terminal count of a cycle counter that must span 'clks' cycles.
    function automatic logic [CNT_W-1:0] last_tick(input int unsigned clks);
        return CNT_W'(clks - 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs, with a configurable reset (idle) value.
module sync_2ff #(
    parameter int unsigned     WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. Mid-bit sampling, start-bit glitch rejection, and a single
// frame_err per framing fault (a held-low break reports once, then waits for the line to idle).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1250
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [CNT_W-1:0]     FULL_LAST = last_tick(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     HALF_LAST = last_tick(CLKS_PER_BIT / 2);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0] bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_c;
    logic                 rx_s;
    logic                 timed;
    logic                 tick;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (IDLE_LEVEL)
    ) u_sync_rx (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (rx),
        .q_o    (rx_s)
    );

    // START waits half a bit to land on the start-bit centre; later states wait whole bits.
    assign timed = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    assign tick  = timed && ((state_q == ST_START) ? (cnt_q == HALF_LAST) : (cnt_q == FULL_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_s == START_BIT) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                if (tick && (bit_q == LAST_BIT)) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = (rx_s == STOP_BIT) ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s == IDLE_LEVEL) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_c  = (state_q != ST_IDLE);
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        data_d  = data_q;
        if ((state_q == ST_STOP) && tick) begin
            if (rx_s == STOP_BIT) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                ferr_d  = 1'b1;
            end
        end
    end

    // Counter restarts on every state entry and at each sampled bit centre.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        if (!timed || tick || (state_d != state_q)) begin
            cnt_d = '0;
        end
        if (state_q != ST_DATA) begin
            bit_d = '0;
        end else if (tick) begin
            bit_d   = bit_q + 1'b1;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_c;

endmodule
